rng_ctrl: RTL and testbench
===========================

// Module: rng_ctrl
// PURPOSE
//  Sequencer/arbiter for the rng block: drives its enable pins (osc, psd, ptb, use_seed),
//  waits for init done, then shares 32-bit random words among NREQ requesters with
//  round-robin arbitration. Enforces a decorrelation gap between delivered words and
//  periodic perturbation windows. Sits between the rng instance and its consumers, on clk_rng.
// PARAMETERS
//  NREQ        4     number of requesters (2..8)
//  GAP         8     min psd-advance cycles between delivered words (>=1)
//  RESEED      64    words delivered before a perturbation window (>=1)
//  PTB_CYCLES  256   length of perturbation window, cycles (>=1)
//  WARM_TMO    4095  max cycles waiting for i_rng_initdone in WARM
// PORTS
//  clk_rng          in   1     rng clock
//  rst_n            in   1     synchronous active-low reset
//  i_start          in   1     pulse: leave IDLE and start rng
//  i_stop           in   1     level: force IDLE
//  i_seed_mode      in   1     sampled on start: 1 = load i_rng_seed path, 0 = osc fill
//  i_rng_initdone   in   1     from rng o_rng_initdone
//  i_rng_state      in   80    from rng o_rng_state
//  o_rng_osc_en     out  1     to rng i_rng_osc_en
//  o_rng_psd_en     out  1     to rng i_rng_psd_en
//  o_rng_ptb_en     out  1     to rng i_rng_ptb_en
//  o_rng_use_seed   out  1     to rng i_rng_use_seed
//  i_req            in   NREQ  per-requester level request
//  o_gnt            out  NREQ  one-hot grant, 1-cycle pulse
//  o_data           out  32    random word, valid with o_valid
//  o_valid          out  1     1-cycle pulse, coincident with o_gnt
//  o_busy           out  1     1 when state != IDLE
//  o_err            out  1     sticky: WARM timeout; cleared by reset or i_start
// BEHAVIOUR
//  Reset (rst_n=0 at clk_rng edge): state=IDLE; all outputs 0; rr pointer=0; counters=0.
//  FSM states IDLE, WARM, RUN, PTB, GRANT. i_stop=1 wins: next state IDLE from any
//  state, in-flight grant dropped (no o_valid), enables low next cycle.
//  IDLE: enables 0. i_start & !i_stop -> WARM; latch seed_mode; clear o_err; warm cnt=0.
//  WARM: osc_en=1, psd_en=1, use_seed=seed_mode. i_rng_initdone -> RUN, gap cnt=0,
//   word cnt=0. warm cnt reaches WARM_TMO without initdone -> IDLE, o_err=1.
//  RUN: osc_en=1, psd_en=1, use_seed=0; gap cnt increments, saturates at GAP.
//   gap cnt==GAP & |i_req -> GRANT; winner = first set i_req at/after rr pointer (wrap).
//  GRANT (1 cycle): o_gnt=onehot(winner), o_valid=1,
//   o_data = i_rng_state[79:48] ^ i_rng_state[31:0] (state as seen this cycle);
//   rr pointer = (winner+1) mod NREQ; gap cnt=0; word cnt++.
//   Next: word cnt==RESEED -> PTB (word cnt=0, ptb cnt=0), else RUN.
//  PTB: as RUN plus ptb_en=1; no grants; ptb cnt reaches PTB_CYCLES-1 -> RUN, gap cnt=0.
//  Request dropped before GRANT: arbitration uses i_req of the RUN->GRANT cycle only.
//  Grant latency: >= GAP+1 cycles after entering RUN; back-to-back words >= GAP+1 apart.
//  i_start while busy ignored. i_rng_initdone falling in RUN/PTB: no effect.
//  Counters widths: clog2 of their max + 1; no wrap before saturation/compare.
// TESTING
//  1 reset, i_start, seed_mode=0, initdone after 100 cyc -> osc/psd high from WARM, RUN at 101.
//  2 NREQ=4, i_req=4'b1111 held -> grants 0001,0010,0100,1000,0001 each GAP+1 cycles apart.
//  3 i_req=4'b0100 only, rr ptr=3 -> gnt=0100; o_data = state[79:48]^state[31:0] that cycle.
//  4 RESEED=2, PTB_CYCLES=5 -> after 2nd o_valid, ptb_en high exactly 5 cycles, no gnt.
//  5 initdone never -> IDLE after WARM_TMO cycles, o_err=1; next i_start clears o_err.
//  6 i_stop in GRANT-pending cycle -> no o_valid, IDLE next, all enables 0; rst_n mid-RUN same.

Source files
------------

// File: rtl/rng_ctrl_if.sv
// Consumer-side bus of the rng sequencer: level requests in, one-hot grant plus
// 32-bit random word out.
//   req   : per-requester level request (driven by the consumers)
//   gnt   : one-hot grant, 1-cycle pulse
//   data  : random word, valid while valid=1
//   valid : 1-cycle pulse, coincident with gnt
interface rng_ctrl_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [31:0]     data;
  logic            valid;

  modport master (output req, input gnt, data, valid);
  modport slave  (input req, output gnt, data, valid);
endinterface

// File: rtl/rng_ctrl.sv
// Sequencer/arbiter for the rng block. Drives the rng enables, waits for init done,
// then hands out 32-bit random words to NREQ requesters in round-robin order, keeping
// a decorrelation gap between words and a perturbation window every RESEED words.
//   clk_rng, rst_n      : clock, synchronous active-low reset
//   i_start / i_stop    : start pulse / force-idle level
//   i_seed_mode         : latched on start, drives use_seed during warm-up
//   i_rng_initdone      : rng init finished
//   i_rng_state         : rng internal state, source of the delivered words
//   o_rng_*_en          : rng enables (osc, psd, ptb, use_seed)
//   cons                : consumer bus (req / gnt / data / valid)
//   o_busy, o_err       : not idle / sticky warm-up timeout
module rng_ctrl #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned GAP        = 8,
  parameter int unsigned RESEED     = 64,
  parameter int unsigned PTB_CYCLES = 256,
  parameter int unsigned WARM_TMO   = 4095
) (
  input  logic             clk_rng,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_seed_mode,
  input  logic             i_rng_initdone,
  input  logic [79:0]      i_rng_state,
  output logic             o_rng_osc_en,
  output logic             o_rng_psd_en,
  output logic             o_rng_ptb_en,
  output logic             o_rng_use_seed,
  rng_ctrl_if.slave        cons,
  output logic             o_busy,
  output logic             o_err
);

  localparam int unsigned PtrW  = $clog2(NREQ);
  localparam int unsigned WarmW = $clog2(WARM_TMO + 1);
  localparam int unsigned GapW  = $clog2(GAP + 1);
  localparam int unsigned WordW = $clog2(RESEED + 1);
  localparam int unsigned PtbW  = $clog2(PTB_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StWarm, StRun, StPtb, StGrant} state_e;

  state_e            state_q, state_d;
  logic [WarmW-1:0]  warm_q, warm_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [WordW-1:0]  word_q, word_d;
  logic [PtbW-1:0]   ptb_q, ptb_d;
  logic [PtrW-1:0]   rr_q, rr_d;
  logic [PtrW-1:0]   win_q, win_d;
  logic              seed_q, seed_d;
  logic              err_q, err_d;

  logic [PtrW-1:0]   winner;
  logic              found;
  logic [PtrW:0]     idx;

  // Bits 47:32 of the rng state do not contribute to the delivered word.
  logic unused_state;
  assign unused_state = ^i_rng_state[47:32];

  // Round-robin pick: first asserted request at or after rr_q, wrapping.
  always_comb begin
    winner = rr_q;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_q} + (PtrW + 1)'(i);
      if (idx >= (PtrW + 1)'(NREQ)) idx = idx - (PtrW + 1)'(NREQ);
      if (!found && cons.req[PtrW'(idx)]) begin
        found  = 1'b1;
        winner = PtrW'(idx);
      end
    end
  end

  // Outputs decoded from the current state; i_stop only suppresses the grant.
  always_comb begin
    o_rng_osc_en   = 1'b0;
    o_rng_psd_en   = 1'b0;
    o_rng_ptb_en   = 1'b0;
    o_rng_use_seed = 1'b0;
    cons.gnt       = '0;
    cons.valid     = 1'b0;
    cons.data      = '0;
    unique case (state_q)
      StWarm: begin
        o_rng_osc_en   = 1'b1;
        o_rng_psd_en   = 1'b1;
        o_rng_use_seed = seed_q;
      end
      StRun: begin
        o_rng_osc_en = 1'b1;
        o_rng_psd_en = 1'b1;
      end
      StPtb: begin
        o_rng_osc_en = 1'b1;
        o_rng_psd_en = 1'b1;
        o_rng_ptb_en = 1'b1;
      end
      StGrant: begin
        o_rng_osc_en = 1'b1;
        o_rng_psd_en = 1'b1;
        if (!i_stop) begin
          cons.gnt   = NREQ'(1) << win_q;
          cons.valid = 1'b1;
          cons.data  = i_rng_state[79:48] ^ i_rng_state[31:0];
        end
      end
      default: ;
    endcase
  end

  assign o_busy = (state_q != StIdle);
  assign o_err  = err_q;

  // Next-state logic; i_stop freezes every register except the state.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    gap_d   = gap_q;
    word_d  = word_q;
    ptb_d   = ptb_q;
    rr_d    = rr_q;
    win_d   = win_q;
    seed_d  = seed_q;
    err_d   = err_q;
    if (i_stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            state_d = StWarm;
            seed_d  = i_seed_mode;
            err_d   = 1'b0;
            warm_d  = '0;
          end
        end
        StWarm: begin
          if (i_rng_initdone) begin
            state_d = StRun;
            gap_d   = '0;
            word_d  = '0;
          end else if (warm_q == WarmW'(WARM_TMO - 1)) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
        StRun: begin
          if (gap_q == GapW'(GAP) && |cons.req) begin
            state_d = StGrant;
            win_d   = winner;
          end else if (gap_q != GapW'(GAP)) begin
            gap_d = gap_q + 1'b1;
          end
        end
        StGrant: begin
          rr_d  = (win_q == PtrW'(NREQ - 1)) ? '0 : win_q + 1'b1;
          // The grant cycle itself is the first psd-advance cycle of the next gap,
          // so back-to-back words land exactly GAP+1 cycles apart.
          gap_d = GapW'(1);
          if (word_q == WordW'(RESEED - 1)) begin
            state_d = StPtb;
            word_d  = '0;
            ptb_d   = '0;
          end else begin
            state_d = StRun;
            word_d  = word_q + 1'b1;
          end
        end
        StPtb: begin
          if (ptb_q == PtbW'(PTB_CYCLES - 1)) begin
            state_d = StRun;
            gap_d   = '0;
          end else begin
            ptb_d = ptb_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_rng) begin
    if (!rst_n) begin
      state_q <= StIdle;
      warm_q  <= '0;
      gap_q   <= '0;
      word_q  <= '0;
      ptb_q   <= '0;
      rr_q    <= '0;
      win_q   <= '0;
      seed_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      ptb_q   <= ptb_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rng_ctrl.sv
module tb_rng_ctrl;
  localparam int NREQ       = 4;
  localparam int GAP        = 4;
  localparam int RESEED     = 2;
  localparam int PTB_CYCLES = 5;
  localparam int WARM_TMO   = 150;

  logic        clk_rng = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_seed_mode = 1'b0;
  logic        i_rng_initdone = 1'b0;
  logic [79:0] i_rng_state = '0;
  logic        osc_en, psd_en, ptb_en, use_seed, busy, err;

  rng_ctrl_if #(.NREQ(NREQ)) bus ();

  rng_ctrl #(
    .NREQ(NREQ), .GAP(GAP), .RESEED(RESEED), .PTB_CYCLES(PTB_CYCLES), .WARM_TMO(WARM_TMO)
  ) dut (
    .clk_rng        (clk_rng),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_stop         (i_stop),
    .i_seed_mode    (i_seed_mode),
    .i_rng_initdone (i_rng_initdone),
    .i_rng_state    (i_rng_state),
    .o_rng_osc_en   (osc_en),
    .o_rng_psd_en   (psd_en),
    .o_rng_ptb_en   (ptb_en),
    .o_rng_use_seed (use_seed),
    .cons           (bus.slave),
    .o_busy         (busy),
    .o_err          (err)
  );

  always #5 clk_rng = ~clk_rng;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: tracks elapsed times and counts rather than FSM states.
  bit m_busy, m_warm, m_seed, m_err;
  int m_warm_n, m_ptb_left, m_since, m_words, m_rr, m_win = -1;
  int cyc = 0;
  int ptb_total = 0;
  int gnt_log[$];
  int gnt_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_busy = 0; m_warm = 0; m_err = 0; m_seed = 0; m_ptb_left = 0;
      m_rr = 0; m_win = -1; m_words = 0; m_since = 0; m_warm_n = 0;
    end else if (i_stop) begin
      m_busy = 0; m_warm = 0; m_ptb_left = 0; m_win = -1;
    end else if (!m_busy) begin
      if (i_start) begin
        m_busy = 1; m_warm = 1; m_warm_n = 0; m_seed = i_seed_mode; m_err = 0;
      end
    end else if (m_warm) begin
      if (i_rng_initdone) begin
        m_warm = 0; m_since = 0; m_words = 0;
      end else begin
        m_warm_n++;
        if (m_warm_n == WARM_TMO) begin
          m_busy = 0; m_warm = 0; m_err = 1;
        end
      end
    end else if (m_win >= 0) begin
      m_rr = (m_win + 1) % NREQ;
      m_win = -1;
      m_since = 1;
      m_words++;
      if (m_words == RESEED) begin
        m_words = 0;
        m_ptb_left = PTB_CYCLES;
      end
    end else if (m_ptb_left > 0) begin
      m_ptb_left--;
      if (m_ptb_left == 0) m_since = 0;
    end else if (m_since >= GAP && bus.req != 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_rr + k) % NREQ;
        if (m_win < 0 && bus.req[idx]) m_win = idx;
      end
    end else begin
      m_since++;
    end
  endtask

  // One clock: compare mid-cycle, advance the model, then new random rng state.
  task automatic step();
    bit              e_valid;
    logic [NREQ-1:0] e_gnt;
    logic [31:0]     e_data;
    @(negedge clk_rng);
    e_valid = (m_win >= 0) && !i_stop;
    e_gnt   = e_valid ? (NREQ'(1) << m_win) : '0;
    e_data  = e_valid ? (i_rng_state[79:48] ^ i_rng_state[31:0]) : 32'h0;
    chk("busy",     busy,      m_busy);
    chk("osc_en",   osc_en,    m_busy);
    chk("psd_en",   psd_en,    m_busy);
    chk("ptb_en",   ptb_en,    m_ptb_left > 0);
    chk("use_seed", use_seed,  m_busy && m_warm && m_seed);
    chk("gnt",      bus.gnt,   e_gnt);
    chk("valid",    bus.valid, e_valid);
    chk("data",     bus.data,  e_data);
    chk("err",      err,       m_err);
    if (ptb_en) ptb_total++;
    if (bus.valid) begin
      for (int k = 0; k < NREQ; k++) if (bus.gnt[k]) gnt_log.push_back(k);
      gnt_cyc.push_back(cyc);
    end
    model_update();
    cyc++;
    @(posedge clk_rng);
    #1;
    i_rng_state = {16'($urandom), $urandom, $urandom};
  endtask

  task automatic wait_grants(input int n, input int budget);
    while (gnt_log.size() < n && budget > 0) begin
      step();
      budget--;
    end
    chk("grant_count", gnt_log.size(), n);
  endtask

  initial begin
    bus.req = '0;
    @(posedge clk_rng);
    #1;
    step();                      // reset held: every output must read 0
    rst_n = 1'b1;

    // 1: osc-fill start, init done after 100 cycles.
    i_seed_mode = 1'b0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (100) step();
    i_rng_initdone = 1'b1;
    step();
    chk("run_entered", busy, 1'b1);

    // 2: all requesters active, rotating grants and perturbation windows.
    bus.req = 4'b1111;
    wait_grants(5, 200);
    if (gnt_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("rr_order", gnt_log[k], k % NREQ);
      chk("spacing", gnt_cyc[1] - gnt_cyc[0], GAP + 1);
      chk("ptb_spacing", gnt_cyc[2] - gnt_cyc[1], PTB_CYCLES + GAP + 2);
      chk("ptb_total", ptb_total, 2 * PTB_CYCLES);
    end

    // 3: lone requester 2 with pointer then at 3; data checked by the model.
    bus.req = 4'b0100;
    wait_grants(7, 200);
    if (gnt_log.size() >= 7) chk("lone_req", gnt_log[6], 2);

    // Random requests, start pulses while busy and initdone dropping.
    for (int i = 0; i < 300; i++) begin
      bus.req = NREQ'($urandom);
      i_start = ($urandom_range(0, 15) == 0);
      i_rng_initdone = ($urandom_range(0, 3) != 0);
      step();
    end
    i_start = 1'b0;
    i_rng_initdone = 1'b1;

    // 6: stop while a grant is pending.
    bus.req = 4'b1111;
    for (int i = 0; i < 60 && m_win < 0; i++) step();
    chk("grant_pending", m_win >= 0, 1'b1);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    step();
    chk("stopped_idle", busy, 1'b0);

    // Restart, then reset in the middle of RUN.
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (12) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("reset_idle", busy, 1'b0);

    // 5: seeded start, init never completes.
    i_rng_initdone = 1'b0;
    i_seed_mode = 1'b1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (WARM_TMO + 3) step();
    chk("tmo_err", err, 1'b1);
    chk("tmo_idle", busy, 1'b0);
    i_seed_mode = 1'b0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    chk("err_cleared", err, 1'b0);
    i_rng_initdone = 1'b1;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
